// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_BLOCK = 2'd2
    } dl_state_e;

    localparam int DEF_THRESH = 16;
    localparam int DEF_CNT_W  = 16;

    // ceil(log2(n)), but never below 1 so single-entry vectors still get a bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest asserted request plus an any flag.
module hls_deadlock_prio_enc
    import hls_deadlock_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        idx = '0;
        any = |req;
        // scan high to low so the lowest set bit is the last write
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/hls_deadlock_persist_monitor.sv
// Persistent-block monitor for one dataflow process; block asserts after THRESH cycles of cond.
// Build option: DEADLOCK_MON_STICKY_EN makes S_BLOCK absorbing (only clear/reset exit).
module hls_deadlock_persist_monitor
    import hls_deadlock_pkg::*;
#(
    parameter int              N_AXIS    = 4,
    parameter int              N_IDLE    = 14,
    parameter int              N_INST    = 7,
    parameter logic [N_AXIS-1:0] AXIS_MASK = 4'b0111,
    parameter int              THRESH    = DEF_THRESH,
    parameter int              CNT_W     = DEF_CNT_W,
    localparam int             SRC_W     = clog2_min1(N_AXIS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_IDLE-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic [SRC_W-1:0]  block_src,
    output logic              block_src_vld,
    output logic [CNT_W-1:0]  block_cycles
);

    localparam int PW = clog2_min1(THRESH + 1);

    dl_state_e         state, state_n;
    logic [PW-1:0]     persist, persist_n;
    logic              enter;
    logic              cond;
    logic [N_AXIS-1:0] axis_m;
    logic [SRC_W-1:0]  enc_idx;
    logic              enc_any;

    assign axis_m = axis_block_sigs & AXIS_MASK;
    // every sibling idle means nothing is actually waiting, so no deadlock
    assign cond   = (&inst_idle_sigs) ? 1'b0 : ((|axis_m) | (|inst_block_sigs));

    hls_deadlock_prio_enc #(.N(N_AXIS), .W(SRC_W)) u_prio_enc (
        .req (axis_m),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        state_n   = state;
        persist_n = persist;
        enter     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cond) begin
                    if (THRESH == 1) begin
                        state_n   = S_BLOCK;
                        persist_n = '0;
                        enter     = 1'b1;
                    end else begin
                        state_n   = S_ARM;
                        persist_n = PW'(1);
                    end
                end
            end
            S_ARM: begin
                if (!cond) begin
                    state_n   = S_IDLE;
                    persist_n = '0;
                end else if (persist == PW'(THRESH - 1)) begin
                    state_n   = S_BLOCK;
                    persist_n = '0;
                    enter     = 1'b1;
                end else begin
                    persist_n = persist + PW'(1);
                end
            end
            S_BLOCK: begin
                persist_n = '0;
`ifdef DEADLOCK_MON_STICKY_EN
                state_n   = S_BLOCK;
`else
                if (!cond) state_n = S_IDLE;
`endif
            end
            default: begin
                state_n   = S_IDLE;
                persist_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state         <= S_IDLE;
            persist       <= '0;
            block_src     <= '0;
            block_src_vld <= 1'b0;
            block_cycles  <= '0;
        end else begin
            state   <= state_n;
            persist <= persist_n;
            if (enter) begin
                block_src     <= enc_idx;
                block_src_vld <= enc_any;
                block_cycles  <= '0;
            end else if (state == S_BLOCK && block_cycles != {CNT_W{1'b1}}) begin
                // counts cycles spent in S_BLOCK, including the exit cycle
                block_cycles <= block_cycles + CNT_W'(1);
            end
        end
    end

    assign block = (state == S_BLOCK);

endmodule
